// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between fetch and data ports; `define ARB_ROUND_ROBIN_EN for round-robin, else data has fixed priority
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  logic last_gnt;
  logic resp_pending;
  logic resp_owner;
  logic fetch_wins;
  // pick a winner and steer its request onto the RAM port; reset blocks all grants
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    fetch_wins = ~d_req | last_gnt;
`else
    fetch_wins = ~d_req | (1'b0 & last_gnt);
`endif
    if_gnt    = ~rst & if_req & fetch_wins;
    d_gnt     = ~rst & d_req & ~if_gnt;
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
  end
  // route last cycle's read data to whoever issued it; reset drops an in-flight response
  always_comb begin
    if_rvalid = ~rst & resp_pending & ~resp_owner;
    d_rvalid  = ~rst & resp_pending & resp_owner;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end
  // remember the last winner and whether a read response is due next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt     <= 1'b1;
      resp_pending <= 1'b0;
      resp_owner   <= 1'b0;
    end else begin
      resp_pending <= mem_en & ~mem_we;
      if (mem_en) begin
        last_gnt   <= d_gnt;
        resp_owner <= d_gnt;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random checks of mem_arbiter against a transaction-level reference
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          m_last = 1'b1;
  bit          m_pend = 1'b0;
  bit          m_owner = 1'b0;
  logic [31:0] m_data = '0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM with one-cycle read latency
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[9:2]];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] dd, output bit ig, output bit dg);
    bit e_if, e_d, e_iv, e_dv;
    logic [31:0] ea, ewd;
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    e_if = 1'b0;
    e_d  = 1'b0;
    if (!r && ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (m_last) e_if = 1'b1; else e_d = 1'b1;
`else
      e_d = 1'b1;
`endif
    end else if (!r) begin
      e_if = ir;
      e_d  = dr;
    end
    ea   = e_d ? da : e_if ? ia : 32'h0;
    ewd  = e_d ? dd : 32'h0;
    e_iv = !r && m_pend && !m_owner;
    e_dv = !r && m_pend && m_owner;
    #1;
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, e_d});
    chk("mem_en", {31'b0, mem_en}, {31'b0, e_if | e_d});
    chk("mem_we", {31'b0, mem_we}, {31'b0, e_d & dw});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ewd);
    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_iv});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, e_dv});
    chk("if_rdata", if_rdata, e_iv ? m_data : 32'h0);
    chk("d_rdata", d_rdata, e_dv ? m_data : 32'h0);
    ig = e_if;
    dg = e_d;
    @(posedge clk);
    if (r) begin
      m_pend = 1'b0;
      m_last = 1'b1;
    end else begin
      m_pend = e_if || (e_d && !dw);
      if (e_if || e_d) begin
        m_last  = e_d;
        m_owner = e_d;
      end
      if (e_if) m_data = ref_mem[ia[9:2]];
      else if (e_d && !dw) m_data = ref_mem[da[9:2]];
      if (e_d && dw) ref_mem[da[9:2]] = dd;
    end
    @(negedge clk);
  endtask

  initial begin
    bit ig, dg, ip, dp, dwe, r;
    logic [31:0] ia, da, dwd, v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
    ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h40, 1, 0, 32'h80, 32'h5, ig, dg);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(0, 1, 32'h0, 0, 0, 0, 0, ig, dg);
    step(0, 1, 32'h4, 0, 0, 0, 0, ig, dg);
    step(0, 1, 32'h8, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, ig, dg);
    step(0, 0, 0, 1, 0, 32'h100, 32'h0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h10 + 4 * i, 1, 0, 32'h20 + 4 * i, 0, ig, dg);
    step(0, 1, 32'h30, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(0, 1, 32'h44, 0, 0, 0, 0, ig, dg);
    step(1, 1, 32'h48, 1, 0, 32'h4C, 0, ig, dg);
    step(0, 1, 32'h48, 1, 0, 32'h4C, 0, ig, dg);
    step(0, 1, 32'h50, 1, 0, 32'h4C, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dwe = 1'b0; dwd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!ip) begin
        ip = $urandom_range(0, 3) != 0;
        ia = {22'b0, 8'($urandom), 2'b0};
      end
      if (!dp) begin
        dp  = $urandom_range(0, 2) != 0;
        da  = {22'b0, 8'($urandom), 2'b0};
        dwe = $urandom_range(0, 1) == 1;
        dwd = $urandom;
      end
      r = $urandom_range(0, 39) == 0;
      step(r, ip, ia, dp, dwe, da, dwd, ig, dg);
      if (ig) ip = 1'b0;
      if (dg) dp = 1'b0;
    end
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port, word-addressed RAM between two requesters, the instruction-fetch port and the data (load/store) port, so fetch and data accesses share one memory array. Sits between the fetch stage and the datapath's data-memory interface and replaces direct RAM wiring once instruction and data memory are unified. One access is issued per cycle. Read data returns one cycle after grant, routed back to the requester that issued it.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width of both request ports and the RAM address.
- DATA_WIDTH, 32, data word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until granted.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DATA_WIDTH  fetched word.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid (loads only).
- d_rdata  out  DATA_WIDTH  loaded word.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address, passed through from the winner.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read with mem_en=1 and mem_we=0.

## Operation
- Grant logic is combinational from the requests and the state registers. At most one of if_gnt and d_gnt is high in a cycle.
- mem_en = if_gnt | d_gnt. mem_we = d_gnt & d_we. mem_addr and mem_wdata are muxed from the winner. When idle, mem_addr and mem_wdata are 0.
- State registers:
  - last_gnt: 0 = fetch, 1 = data.
  - resp_pending: 1 bit.
  - resp_owner: 0 = fetch, 1 = data.
- On any read grant, resp_pending is set to 1 and resp_owner is set to the winner. Otherwise resp_pending is set to 0.
- Response: if_rvalid = resp_pending & ~resp_owner. d_rvalid = resp_pending & resp_owner. The matching rdata equals mem_rdata. Non-owner rdata is 0.
- Stores complete at grant. They produce no rvalid.
- Back-to-back grants are allowed every cycle. A response and a new grant can occur in the same cycle.
- A request with req low is never granted. A requester deasserting req before its grant is a protocol violation and produces undefined behaviour.

## Timing
- Reset values: if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, mem_en=0, mem_we=0, last_gnt=1 (fetch wins the first contention), resp_pending=0.
- While rst=1, all grants and mem_en are forced to 0.
- Grant latency: 0 cycles if the requester wins arbitration.
- Read data latency: exactly 1 cycle after the grant edge.
- Reset asserted the cycle after a read grant drops that response: rvalid stays 0.
- Single requester: granted every cycle it requests, with no bubbles.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Contention is resolved round-robin. The port not equal to last_gnt wins.
  - last_gnt updates on every grant.
  - With both requesting continuously, grants alternate and neither port waits more than 1 cycle.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: data wins every contention, so loads and stores never stall behind fetch.
  - last_gnt is still maintained but ignored.
  - Fetch may starve while d_req stays high.

## Test plan
- Reset, then idle: all outputs 0 for 5 cycles, mem_en=0.
- Fetch only:
  - Stimulus: if_req=1 with if_addr=0x0, 0x4, 0x8 on consecutive cycles; RAM returns 0x11, 0x22, 0x33.
  - Required: if_gnt=1 each cycle, if_rvalid=1 on each following cycle with if_rdata=0x11, 0x22, 0x33, d_rvalid=0 throughout.
- Store then load to the same address:
  - Stimulus: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, then d_we=0, d_addr=0x100.
  - Required: store cycle has mem_we=1 and no d_rvalid; load returns d_rvalid=1 with d_rdata=0xDEADBEEF one cycle after its grant.
- Contention, round-robin build:
  - Stimulus: if_req and d_req held high for 4 cycles after reset.
  - Required: grant order fetch, data, fetch, data. Each rvalid goes to the correct port with its own data.
- Contention, fixed-priority build:
  - Stimulus: same stimulus as the round-robin case.
  - Required: d_gnt on all 4 cycles, if_gnt=0. Fetch is granted in the cycle d_req drops.
- Reset mid-operation:
  - Stimulus: read granted at cycle N, rst=1 at cycle N+1.
  - Required: if_rvalid=0 and d_rvalid=0 at N+1. After rst is released, the first contention goes to fetch.
